// File: rtl/dyn_clk_div_if.sv
// Reconfiguration access port of dyn_clk_div: channel select, {HIGH, DIVIDE} data,
// access strobe / write enable, and read data with its one-cycle DRDY acknowledge.
interface dyn_clk_div_if #(
    parameter int DIV_WIDTH = 8
);
    logic [2:0]             DADDR;
    logic [2*DIV_WIDTH-1:0] DI;
    logic                   DEN;
    logic                   DWE;
    logic [2*DIV_WIDTH-1:0] DO;
    logic                   DRDY;

    modport master (output DADDR, DI, DEN, DWE, input DO, DRDY);
    modport slave  (input DADDR, DI, DEN, DWE, output DO, DRDY);
endinterface

// File: rtl/dyn_clk_div.sv
// Multi-channel runtime-reconfigurable clock divider with lock indication.
// Optional macro DYN_CLK_DIV_ALIGN_EN: any valid write restarts all channels phase-aligned.
module dyn_clk_div #(
    parameter int CHANNELS       = 6,
    parameter int DIV_WIDTH      = 8,
    parameter int LOCK_CYCLES    = 16,
    parameter int DEFAULT_DIVIDE = 2,
    parameter int DEFAULT_HIGH   = 1
) (
    input  logic                CLKIN,
    input  logic                RST_N,
    input  logic                PWRDWN,
    dyn_clk_div_if.slave        drp,
    output logic [CHANNELS-1:0] CLKOUT,
    output logic                LOCKED
);

    localparam int W = DIV_WIDTH;
    typedef logic [W-1:0]   fld_t;
    typedef logic [2*W-1:0] cfg_t;
    localparam cfg_t RST_CFG = {W'(DEFAULT_HIGH), W'(DEFAULT_DIVIDE)};

    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_LOCKED} state_t;

    cfg_t                shadow_q [CHANNELS];
    cfg_t                shadow_d [CHANNELS];
    fld_t                div_q    [CHANNELS];
    fld_t                div_d    [CHANNELS];
    fld_t                high_q   [CHANNELS];
    fld_t                high_d   [CHANNELS];
    fld_t                cnt_q    [CHANNELS];
    fld_t                cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] clkout_q, clkout_d;
    logic [CHANNELS-1:0] wr_hit, load;
    logic                drdy_q, drdy_d;
    cfg_t                do_q, do_d;
    logic                addr_ok, wr_valid;

    state_t              state_q;
    logic [15:0]         lock_cnt_q;
    logic                locked_q;

    // Active settings never hold a degenerate ratio: DIVIDE>=2, 1<=HIGH<DIVIDE.
    function automatic cfg_t clamp_cfg(input cfg_t cfg);
        fld_t d;
        fld_t h;
        d = cfg[W-1:0];
        h = cfg[2*W-1:W];
        if (d < fld_t'(2)) d = fld_t'(2);
        if (h == '0) h = fld_t'(1);
        if (h >= d) h = d - fld_t'(1);
        return {h, d};
    endfunction

    always_comb begin
        addr_ok  = ({29'd0, drp.DADDR} < 32'(CHANNELS));
        wr_valid = drp.DEN && drp.DWE && addr_ok;
        drdy_d   = drp.DEN;
        do_d     = '0;
        wr_hit   = '0;
        load     = '0;
        clkout_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            div_d[i]    = div_q[i];
            high_d[i]   = high_q[i];
            cnt_d[i]    = cnt_q[i];
            wr_hit[i]   = wr_valid && (drp.DADDR == 3'(i));
            clkout_d[i] = !PWRDWN && (cnt_q[i] < high_q[i]);

            if (PWRDWN) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= div_q[i] - fld_t'(1)) begin
                cnt_d[i] = '0;
                load[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + fld_t'(1);
            end
`ifdef DYN_CLK_DIV_ALIGN_EN
            if (wr_valid) begin
                cnt_d[i] = '0;
                load[i]  = 1'b1;
            end
`endif
            // A write landing on the reload edge takes effect immediately.
            if (load[i]) {high_d[i], div_d[i]} = clamp_cfg(wr_hit[i] ? drp.DI : shadow_q[i]);
            if (wr_hit[i]) shadow_d[i] = drp.DI;
            if (drp.DEN && !drp.DWE && (drp.DADDR == 3'(i))) do_d = shadow_q[i];
        end
    end

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= RST_CFG;
                div_q[i]    <= W'(DEFAULT_DIVIDE);
                high_q[i]   <= W'(DEFAULT_HIGH);
                cnt_q[i]    <= '0;
            end
            clkout_q <= '0;
            drdy_q   <= 1'b0;
            do_q     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                div_q[i]    <= div_d[i];
                high_q[i]   <= high_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            clkout_q <= clkout_d;
            drdy_q   <= drdy_d;
            do_q     <= do_d;
        end
    end

    always_ff @(posedge CLKIN or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (PWRDWN) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (wr_valid) begin
            state_q    <= ST_COUNT;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_COUNT;
                    lock_cnt_q <= '0;
                    locked_q   <= 1'b0;
                end
                ST_COUNT: begin
                    if (lock_cnt_q == 16'(LOCK_CYCLES - 1)) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 16'd1;
                    end
                end
                ST_LOCKED: locked_q <= 1'b1;
                default: begin
                    state_q  <= ST_IDLE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign CLKOUT   = clkout_q;
    assign LOCKED   = locked_q;
    assign drp.DO   = do_q;
    assign drp.DRDY = drdy_q;

endmodule

// File: tb/tb_dyn_clk_div.sv
// Randomized bench for dyn_clk_div against a behavioural period/lock-age model.
module tb_dyn_clk_div;

    localparam int CH   = 6;
    localparam int LOCK = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pwrdwn = 1'b1;
    logic [CH-1:0] clkout;
    logic          locked;

    dyn_clk_div_if #(.DIV_WIDTH(8)) drp ();

    dyn_clk_div #(.CHANNELS(CH), .DIV_WIDTH(8), .LOCK_CYCLES(LOCK),
                  .DEFAULT_DIVIDE(2), .DEFAULT_HIGH(1)) dut (
        .CLKIN(clk), .RST_N(rst_n), .PWRDWN(pwrdwn), .drp(drp.slave),
        .CLKOUT(clkout), .LOCKED(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: position within period, clamped period/high time, lock age.
    int          m_pos  [8];
    int          m_div  [8];
    int          m_high [8];
    logic [15:0] m_shadow [8];
    int          m_age;
    logic [CH-1:0] exp_clk;
    logic        exp_locked, exp_drdy;
    logic [15:0] exp_do;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_cfg(input int i, input logic [15:0] v);
        int d, h;
        d = int'(v[7:0]);
        h = int'(v[15:8]);
        if (d < 2) d = 2;
        if (h == 0) h = 1;
        if (h >= d) h = d - 1;
        m_div[i]  = d;
        m_high[i] = h;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 16'h0102;
            m_div[i] = 2;
            m_high[i] = 1;
            m_pos[i] = 0;
        end
        m_age = -1;
        exp_clk = '0;
        exp_locked = 1'b0;
        exp_drdy = 1'b0;
        exp_do = '0;
    endtask

    task automatic model_edge();
        bit wv;
        int a;
        a  = int'(drp.DADDR);
        wv = drp.DEN && drp.DWE && (a < CH);
        exp_drdy = drp.DEN;
        exp_do = (drp.DEN && !drp.DWE && a < CH) ? m_shadow[a] : 16'h0;
        for (int i = 0; i < CH; i++) begin
            exp_clk[i] = !pwrdwn && (m_pos[i] < m_high[i]);
            if (pwrdwn) m_pos[i] = 0;
            else if (m_pos[i] == m_div[i] - 1) begin
                m_pos[i] = 0;
                apply_cfg(i, (wv && a == i) ? drp.DI : m_shadow[i]);
            end else m_pos[i]++;
`ifdef DYN_CLK_DIV_ALIGN_EN
            if (wv) begin
                m_pos[i] = 0;
                apply_cfg(i, (a == i) ? drp.DI : m_shadow[i]);
            end
`endif
        end
        if (wv) m_shadow[a] = drp.DI;
        if (pwrdwn) m_age = -1;
        else if (wv || m_age < 0) m_age = 0;
        else if (m_age < LOCK) m_age++;
        exp_locked = (m_age >= LOCK);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_eq("clkout", 32'(clkout), 32'(exp_clk));
        check_eq("locked", 32'(locked), 32'(exp_locked));
        check_eq("drdy", 32'(drp.DRDY), 32'(exp_drdy));
        check_eq("do", 32'(drp.DO), 32'(exp_do));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic access(input logic we, input logic [2:0] a, input logic [15:0] d);
        drp.DEN = 1'b1;
        drp.DWE = we;
        drp.DADDR = a;
        drp.DI = d;
        step();
        drp.DEN = 1'b0;
        drp.DWE = 1'b0;
    endtask

    initial begin
        drp.DEN = 1'b0;
        drp.DWE = 1'b0;
        drp.DADDR = '0;
        drp.DI = '0;
        model_reset();
        steps(2);

        // Reset asserted while a write is pending: no DRDY, write lost.
        rst_n = 1'b1;
        step();
        drp.DEN = 1'b1;
        drp.DWE = 1'b1;
        drp.DADDR = 3'd0;
        drp.DI = 16'h0307;
        #2 rst_n = 1'b0;
        #1 check_eq("async_rst_clk", 32'(clkout), 32'd0);
        step();
        drp.DEN = 1'b0;
        drp.DWE = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        access(1'b0, 3'd0, 16'h0);
        check_eq("rd_after_rst", 32'(drp.DO), 32'h0102);

        // Release power-down with defaults: divide-by-2 and lock after the count.
        pwrdwn = 1'b0;
        steps(16);
        check_eq("not_locked_yet", 32'(locked), 32'd0);
        step();
        check_eq("locked_default", 32'(locked), 32'd1);
        steps(4);

        access(1'b1, 3'd2, {8'd3, 8'd10});
        check_eq("wr_drdy", 32'(drp.DRDY), 32'd1);
        check_eq("lock_fall", 32'(locked), 32'd0);
        steps(40);

        access(1'b1, 3'd0, 16'h0000);
        steps(8);
        access(1'b1, 3'd0, {8'd12, 8'd5});
        steps(12);
        access(1'b0, 3'd0, 16'h0);
        check_eq("rd_unclamped", 32'(drp.DO), 32'h0C05);
        steps(20);

        access(1'b1, 3'd7, 16'h0203);
        check_eq("bad_addr_drdy", 32'(drp.DRDY), 32'd1);
        check_eq("bad_addr_lock", 32'(locked), 32'd1);
        access(1'b0, 3'd7, 16'h0);
        check_eq("bad_addr_do", 32'(drp.DO), 32'd0);
        steps(3);

        pwrdwn = 1'b1;
        steps(5);
        check_eq("pd_clk", 32'(clkout), 32'd0);
        pwrdwn = 1'b0;
        steps(25);

`ifdef DYN_CLK_DIV_ALIGN_EN
        access(1'b1, 3'd0, {8'd1, 8'd3});
        access(1'b1, 3'd1, {8'd1, 8'd4});
        steps(7);
        access(1'b1, 3'd5, {8'd1, 8'd2});
        step();
        check_eq("align_rise", 32'(clkout), 32'((1 << CH) - 1));
        steps(10);
`endif

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 59) == 0) pwrdwn = ~pwrdwn;
            drp.DEN = ($urandom_range(0, 5) == 0);
            drp.DWE = 1'($urandom_range(0, 1));
            drp.DADDR = 3'($urandom_range(0, 7));
            drp.DI = {4'd0, 4'($urandom), 4'd0, 4'($urandom)};
            step();
        end
        drp.DEN = 1'b0;
        pwrdwn = 1'b0;
        steps(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
